// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matmul processing elements.
//
// Contents:
//   pe_state_t  - per-PE dot-product tracking state (IDLE / ACC)
//   acc_w_min() - smallest accumulator width that cannot overflow for
//                 K_MAX products of two DATA_W operands
//   ACC_W_DFLT and the signed/unsigned bounds for that default width,
//                 for array-level logic built around the default PE.
package systolic_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } pe_state_t;

    // Width needed so that K_MAX full-precision products never overflow.
    function automatic int acc_w_min(input int data_w, input int k_max);
        return 2 * data_w + $clog2(k_max);
    endfunction

    localparam int ACC_W_DFLT = 20;

    // Two's-complement bounds for the default accumulator width.
    localparam logic [ACC_W_DFLT-1:0] SMAX_DFLT = {1'b0, {(ACC_W_DFLT-1){1'b1}}};
    localparam logic [ACC_W_DFLT-1:0] SMIN_DFLT = {1'b1, {(ACC_W_DFLT-1){1'b0}}};

    // Unsigned bounds for the default accumulator width.
    localparam logic [ACC_W_DFLT-1:0] UMAX_DFLT = {ACC_W_DFLT{1'b1}};
    localparam logic [ACC_W_DFLT-1:0] UMIN_DFLT = {ACC_W_DFLT{1'b0}};

endpackage

// File: rtl/mac_pe_os_sat_add.sv
// Combinational accumulate-with-overflow adder.
//
// Adds an ACC_W-bit accumulator to a product that has already been
// sign/zero-extended to ACC_W+1 bits. The sum is formed exactly in
// ACC_W+2 bits, so the overflow test is a plain range check on the
// top bits. Shared with the array-level adder tree.
//
// Ports:
//   acc   in   ACC_W    current accumulator value
//   prod  in   ACC_W+1  extended product
//   sum   out  ACC_W    clamped (SATURATE=1) or wrapped (SATURATE=0) sum
//   ovf   out  1        exact sum fell outside the representable range
module sat_add #(
    parameter int ACC_W    = 20,
    parameter bit SIGNED   = 1'b1,
    parameter bit SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W:0]   prod,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};

    logic [ACC_W+1:0] acc_x;
    logic [ACC_W+1:0] prod_x;
    logic [ACC_W+1:0] sum_x;
    logic [2:0]       top_bits;
    logic             neg;

    always_comb begin
        if (SIGNED) begin
            acc_x  = {{2{acc[ACC_W-1]}}, acc};
            prod_x = {prod[ACC_W], prod};
        end else begin
            acc_x  = {2'b00, acc};
            prod_x = {1'b0, prod};
        end

        sum_x    = acc_x + prod_x;
        top_bits = sum_x[ACC_W+1:ACC_W-1];
        neg      = sum_x[ACC_W+1];

        // Signed: in range only when the two guard bits copy the ACC_W sign bit.
        // Unsigned: operands are non-negative, so any carry out of ACC_W is overflow.
        if (SIGNED) begin
            ovf = !((&top_bits) || !(|top_bits));
        end else begin
            ovf = |sum_x[ACC_W+1:ACC_W];
        end

        sum = sum_x[ACC_W-1:0];
        if (SATURATE && ovf) begin
            if (SIGNED) begin
                sum = neg ? SMIN : SMAX;
            end else begin
                sum = UMAX;
            end
        end
    end

endmodule

// File: rtl/mac_pe_os.sv
// Output-stationary MAC processing element for the systolic matmul arrays.
//
// A flows west->east and B flows north->south through one register each.
// When both operands are valid the PE multiplies them and accumulates;
// in-band first/last tags on the A stream delimit each dot product.
// A finished sum moves into a result register so the next dot product can
// start on the very next cycle, and leaves the array through a drain
// register that either loads the local result or shifts from upstream.
// ACC_W must be at least 2*DATA_W.
//
// Ports:
//   clk, rst                                 clock, synchronous active-high reset
//   a_in, a_vld_in, a_first_in, a_last_in    A operand, valid and tags from the west
//   b_in, b_vld_in                           B operand and valid from the north
//   a_out, a_vld_out, a_first_out, a_last_out  A path registered to the east
//   b_out, b_vld_out                         B path registered to the south
//   drain_load                               copy result register into the drain register
//   drain_shift                              drain register takes res_in (load wins)
//   res_in                                   drain chain input (tie 0 at chain head)
//   res_out                                  drain register
//   res_vld                                  result register holds an unconsumed result
//   res_ovf                                  overflow flag of the result register
//   err_seq                                  sticky tag-protocol / valid-mismatch error
//   err_overrun                              sticky unconsumed-result-overwritten error
module mac_pe_os
    import systolic_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter bit SIGNED   = 1'b1,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic              a_first_in,
    input  logic              a_last_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic              a_first_out,
    output logic              a_last_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_vld_out,
    input  logic              drain_load,
    input  logic              drain_shift,
    input  logic [ACC_W-1:0]  res_in,
    output logic [ACC_W-1:0]  res_out,
    output logic              res_vld,
    output logic              res_ovf,
    output logic              err_seq,
    output logic              err_overrun
);

    pe_state_t state;
    pe_state_t state_nxt;

    logic             fire;
    logic             acc_load;
    logic             acc_add;
    logic             res_cap;
    logic             seq_viol;

    logic [ACC_W:0]   prod_ext;
    logic [ACC_W-1:0] acc;
    logic             ovf_acc;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic [ACC_W-1:0] acc_val;
    logic             ovf_val;
    logic [ACC_W-1:0] result;

    assign fire = a_vld_in & b_vld_in;

    // Full-precision product, extended to ACC_W+1 bits for the adder.
    generate
        if (SIGNED) begin : g_sprod
            logic signed [2*DATA_W-1:0] a_sx;
            logic signed [2*DATA_W-1:0] b_sx;
            logic signed [2*DATA_W-1:0] prod_s;
            assign a_sx     = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in});
            assign b_sx     = $signed({{DATA_W{b_in[DATA_W-1]}}, b_in});
            assign prod_s   = a_sx * b_sx;
            assign prod_ext = {{(ACC_W+1-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
        end else begin : g_uprod
            logic [2*DATA_W-1:0] a_zx;
            logic [2*DATA_W-1:0] b_zx;
            logic [2*DATA_W-1:0] prod_u;
            assign a_zx     = {{DATA_W{1'b0}}, a_in};
            assign b_zx     = {{DATA_W{1'b0}}, b_in};
            assign prod_u   = a_zx * b_zx;
            assign prod_ext = {{(ACC_W+1-2*DATA_W){1'b0}}, prod_u};
        end
    endgenerate

    sat_add #(
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .acc  (acc),
        .prod (prod_ext),
        .sum  (sum),
        .ovf  (add_ovf)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: only a firing cycle can move the FSM.
    always_comb begin
        state_nxt = state;
        if (fire) begin
            case (state)
                IDLE: begin
                    if (a_first_in) begin
                        state_nxt = a_last_in ? IDLE : ACC;
                    end
                end
                ACC: begin
                    state_nxt = a_last_in ? IDLE : ACC;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath controls decoded from state and tags.
    always_comb begin
        acc_load = 1'b0;
        acc_add  = 1'b0;
        res_cap  = 1'b0;
        seq_viol = a_vld_in ^ b_vld_in;
        if (fire) begin
            case (state)
                IDLE: begin
                    if (a_first_in) begin
                        acc_load = 1'b1;
                        res_cap  = a_last_in;
                    end else begin
                        // Product without an opening tag is dropped.
                        seq_viol = 1'b1;
                    end
                end
                ACC: begin
                    if (a_first_in) begin
                        // Unexpected restart: abandon the partial sum.
                        acc_load = 1'b1;
                        seq_viol = 1'b1;
                    end else begin
                        acc_add = 1'b1;
                    end
                    res_cap = a_last_in;
                end
                default: ;
            endcase
        end
    end

    // Value the accumulator takes this cycle, which is also what a
    // closing element hands to the result register.
    always_comb begin
        if (acc_load) begin
            acc_val = prod_ext[ACC_W-1:0];
            ovf_val = 1'b0;
        end else begin
            acc_val = sum;
            ovf_val = ovf_acc | add_ovf;
        end
    end

    // Stage boundary: forwarding, accumulator, result, drain and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out       <= '0;
            a_vld_out   <= 1'b0;
            a_first_out <= 1'b0;
            a_last_out  <= 1'b0;
            b_out       <= '0;
            b_vld_out   <= 1'b0;
            acc         <= '0;
            ovf_acc     <= 1'b0;
            result      <= '0;
            res_ovf     <= 1'b0;
            res_vld     <= 1'b0;
            res_out     <= '0;
            err_seq     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            a_out       <= a_in;
            a_vld_out   <= a_vld_in;
            a_first_out <= a_first_in;
            a_last_out  <= a_last_in;
            b_out       <= b_in;
            b_vld_out   <= b_vld_in;

            if (acc_load || acc_add) begin
                acc     <= acc_val;
                ovf_acc <= ovf_val;
            end

            if (res_cap) begin
                result  <= acc_val;
                res_ovf <= ovf_val;
            end

            // A capture in the same cycle as a drain_load keeps res_vld set:
            // the drain takes the old result, the new one stays pending.
            if (res_cap) begin
                res_vld <= 1'b1;
            end else if (drain_load) begin
                res_vld <= 1'b0;
            end

            if (drain_load) begin
                res_out <= result;
            end else if (drain_shift) begin
                res_out <= res_in;
            end

            if (seq_viol) begin
                err_seq <= 1'b1;
            end

            if (res_cap && res_vld && !drain_load) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule
